// File: rtl/seq_mem_cmd_ctrl.sv
// seq_mem_cmd_ctrl
// Command front-end for a DEPTH x DATA_W scratchpad memory. It accepts
// whole-word writes, single-bit writes and reads on a valid/ready command
// channel. Read data comes back on a one-entry valid/ready response channel.
// After reset, an INIT sweep writes zero to every word before any command is
// accepted.
//
// Optional feature: define SEQ_MEM_CLR_CMD_EN to make the CLR command re-run
// the INIT sweep. When it is undefined, CLR is accepted and does nothing.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 CLR, 01 WR_WORD, 10 WR_BIT, 11 RD
//   cmd_addr             target word
//   cmd_bit_idx          bit position for WR_BIT
//   cmd_wdata            data for WR_WORD
//   cmd_bit_val          value for WR_BIT
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             read result (held while the response is stalled)
//   init_busy            high while the clear sweep runs
//   rd_count             accepted RD commands, modulo 256
module seq_mem_cmd_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [IDX_W-1:0]  cmd_bit_idx,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_bit_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_busy,
  output logic [7:0]        rd_count
);

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;
  typedef enum logic [1:0] {
    OP_CLR     = 2'b00,
    OP_WR_WORD = 2'b01,
    OP_WR_BIT  = 2'b10,
    OP_RD      = 2'b11
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  op_t               op;
  logic              cmd_fire;
  logic              rd_fire;

  assign op = op_t'(cmd_op);

  // The response buffer holds one entry. A new command is taken only if that
  // entry is empty or is being drained at this same edge.
  assign cmd_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rd_fire   = cmd_fire && (op == OP_RD);
  assign init_busy = (state == ST_INIT);

`ifdef SEQ_MEM_CLR_CMD_EN
  logic clr_fire;
  assign clr_fire = cmd_fire && (op == OP_CLR);
`endif

  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // register samples the values from before the edge, whatever order the
  // blocks and statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
`ifdef SEQ_MEM_CLR_CMD_EN
          if (clr_fire) begin
            state <= ST_INIT;
            ptr   <= '0;
          end
`endif
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // The response path does not depend on state. A response that is pending
  // when a CLR sweep starts can still complete its handshake during INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rd_count  <= '0;
    end else begin
      if (rd_fire) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem[cmd_addr];  // value from before this edge's writes
        rd_count  <= rd_count + 8'd1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // NOTE: the memory array has no reset. Resetting it would turn the RAM into
  // a large bank of flops. The INIT sweep clears it instead, one word per
  // cycle.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[ptr] <= '0;
    end else if (cmd_fire) begin
      case (op)
        OP_WR_WORD: mem[cmd_addr] <= cmd_wdata;
        OP_WR_BIT:  mem[cmd_addr][cmd_bit_idx] <= cmd_bit_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mem_cmd_ctrl.sv
// Self-checking bench for seq_mem_cmd_ctrl. A behavioural model tracks the
// memory contents, the cycles left in the clear sweep, the pending response
// and the read count. Each scenario task compares the DUT against the model
// or against constants.
module tb_seq_mem_cmd_ctrl;

  localparam logic [1:0] CLR = 2'b00, WRW = 2'b01, WRB = 2'b10, RD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [2:0] cmd_bit_idx;
  logic [7:0] cmd_wdata;
  logic       cmd_bit_val;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       init_busy;
  logic [7:0] rd_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_mem [16];
  int         m_init_left;
  bit         m_rsp_valid;
  logic [7:0] m_rsp_data;
  logic [7:0] m_rd_count;

  always #5 clk = ~clk;

  seq_mem_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_bit_idx(cmd_bit_idx), .cmd_wdata(cmd_wdata),
    .cmd_bit_val(cmd_bit_val), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .init_busy(init_busy), .rd_count(rd_count)
  );

  function automatic bit m_ready();
    return (m_init_left == 0) && (!m_rsp_valid || rsp_ready);
  endfunction

  task automatic m_reset();
    m_init_left = 16;
    m_rsp_valid = 1'b0;
    m_rsp_data  = 8'h00;
    m_rd_count  = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [3:0] a,
                       input logic [2:0] idx, input logic [7:0] wd,
                       input bit bv, input bit rr);
    cmd_valid   = v;
    cmd_op      = op;
    cmd_addr    = a;
    cmd_bit_idx = idx;
    cmd_wdata   = wd;
    cmd_bit_val = bv;
    rsp_ready   = rr;
    #1;
  endtask

  // Advance the model over one rising edge, then move the DUT to the next
  // falling edge.
  task automatic tick();
    bit acc;
    acc = cmd_valid && m_ready();
    if (m_init_left > 0) m_init_left--;
    if (m_rsp_valid && rsp_ready) m_rsp_valid = 1'b0;
    if (acc) begin
      case (cmd_op)
        WRW: m_mem[cmd_addr] = cmd_wdata;
        WRB: m_mem[cmd_addr][cmd_bit_idx] = cmd_bit_val;
        RD: begin
          m_rsp_data  = m_mem[cmd_addr];
          m_rsp_valid = 1'b1;
          m_rd_count  = m_rd_count + 8'd1;
        end
        default: begin
`ifdef SEQ_MEM_CLR_CMD_EN
          m_init_left = 16;
          for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
`endif
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, RD, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); end
    if (init_busy !== 1'b1) begin n_bad++; $display("FAIL rst_init_busy got=%b exp=1", init_busy); end
    if (rd_count !== 8'h00) begin n_bad++; $display("FAIL rst_rd_count got=%h exp=00", rd_count); end
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_init_hold_rd();
    drive(1, RD, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      n_cmp += 2;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL init_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      if (init_busy !== 1'b1) begin n_bad++; $display("FAIL init_busy cyc=%0d got=%b exp=1", i, init_busy); end
      tick();
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL init_done_ready got=%b exp=1", cmd_ready); end
    tick();
    drive(0, RD, 0, 0, 0, 0, 1);
    n_cmp += 3;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL first_rd_valid got=%b exp=1", rsp_valid); end
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL first_rd_data got=%h exp=00", rsp_data); end
    if (rd_count !== 8'd1) begin n_bad++; $display("FAIL first_rd_count got=%0d exp=1", rd_count); end
  endtask

  task automatic test_write_read();
    drive(1, WRW, 5, 0, 8'hA5, 0, 1); tick();
    drive(1, RD, 5, 0, 0, 0, 1);      tick();
    drive(0, RD, 0, 0, 0, 0, 0);
    n_cmp += 2;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_rd_valid got=%b exp=1", rsp_valid); end
    if (rsp_data !== 8'hA5) begin n_bad++; $display("FAIL wr_rd_data got=%h exp=a5", rsp_data); end
  endtask

  task automatic test_bit_write();
    drive(1, WRW, 3, 0, 8'h0F, 0, 1); tick();
    drive(1, WRB, 3, 7, 8'h00, 1, 1); tick();
    drive(1, WRB, 3, 0, 8'hFF, 0, 1); tick();
    drive(1, RD, 3, 0, 0, 0, 1);      tick();
    drive(0, RD, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (rsp_data !== 8'h8E) begin n_bad++; $display("FAIL bit_wr_data got=%h exp=8e", rsp_data); end
    if (rsp_data !== m_rsp_data) begin n_bad++; $display("FAIL bit_wr_model got=%h exp=%h", rsp_data, m_rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] held;
    logic [7:0] cnt0;
    logic [3:0] a;
    for (int i = 10; i < 14; i++) begin
      drive(1, WRW, 4'(i), 0, 8'($urandom), 0, 1); tick();
    end
    drive(1, RD, 1, 0, 0, 0, 1); tick();
    held = m_mem[1];
    drive(1, RD, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp += 3;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
      if (rsp_data !== held) begin n_bad++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", i, rsp_data, held); end
      tick();
    end
    cnt0 = m_rd_count;
    for (int k = 1; k <= 6; k++) begin
      a = 4'(10 + (k % 4));
      drive(1, RD, a, 0, 0, 0, 1);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, cmd_ready); end
      tick();
      n_cmp += 3;
      if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, rsp_valid); end
      if (rsp_data !== m_mem[a]) begin n_bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rsp_data, m_mem[a]); end
      if (rd_count !== cnt0 + 8'(k)) begin n_bad++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, rd_count, cnt0 + 8'(k)); end
    end
    drive(0, RD, 0, 0, 0, 0, 1); tick();
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL %s_ready got=%b exp=0", tag, cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid got=%b exp=0", tag, rsp_valid); end
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL %s_data got=%h exp=00", tag, rsp_data); end
    if (init_busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy got=%b exp=1", tag, init_busy); end
    if (rd_count !== 8'h00) begin n_bad++; $display("FAIL %s_count got=%h exp=00", tag, rd_count); end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_mid_reset();
    drive(1, WRW, 5, 0, 8'hA5, 0, 1); tick();
    drive(1, RD, 5, 0, 0, 0, 1);      tick();
    drive(0, RD, 0, 0, 0, 0, 0);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid got=%b exp=1", rsp_valid); end
    async_reset_pulse("rst_pending");
    drive(0, RD, 0, 0, 0, 0, 1);
    repeat (5) tick();
    async_reset_pulse("rst_mid_init");
    drive(1, RD, 5, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL resweep_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      tick();
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL resweep_done got=%b exp=1", cmd_ready); end
    tick();
    drive(0, RD, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL resweep_data got=%h exp=00", rsp_data); end
    if (rd_count !== 8'd1) begin n_bad++; $display("FAIL resweep_count got=%0d exp=1", rd_count); end
  endtask

  task automatic test_clr();
    logic [7:0] cnt0;
    drive(1, WRW, 9, 0, 8'h3C, 0, 1); tick();
    cnt0 = m_rd_count;
    drive(1, CLR, 0, 0, 0, 0, 1);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready got=%b exp=1", cmd_ready); end
    tick();
    drive(1, RD, 9, 0, 0, 0, 1);
`ifdef SEQ_MEM_CLR_CMD_EN
    for (int i = 0; i < 16; i++) begin
      n_cmp += 2;
      if (init_busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy cyc=%0d got=%b exp=1", i, init_busy); end
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL clr_sweep_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      tick();
    end
    n_cmp++;
    if (rd_count !== cnt0) begin n_bad++; $display("FAIL clr_count got=%0d exp=%0d", rd_count, cnt0); end
    tick();
    n_cmp++;
    if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL clr_rd_data got=%h exp=00", rsp_data); end
`else
    n_cmp += 3;
    if (init_busy !== 1'b0) begin n_bad++; $display("FAIL nop_busy got=%b exp=0", init_busy); end
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL nop_ready got=%b exp=1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL nop_no_rsp got=%b exp=0", rsp_valid); end
    tick();
    n_cmp += 2;
    if (rsp_data !== 8'h3C) begin n_bad++; $display("FAIL nop_rd_data got=%h exp=3c", rsp_data); end
    if (rd_count !== cnt0 + 8'd1) begin n_bad++; $display("FAIL nop_count got=%0d exp=%0d", rd_count, cnt0 + 8'd1); end
`endif
    drive(0, RD, 0, 0, 0, 0, 1); tick();
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int c = 0; c < 600; c++) begin
      op = ($urandom_range(0, 39) == 0) ? CLR : 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) != 0, op, 4'($urandom), 3'($urandom),
            8'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
      n_cmp += 2;
      if (cmd_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, cmd_ready, m_ready()); end
      if (init_busy !== (m_init_left != 0)) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, init_busy, m_init_left != 0); end
      tick();
      n_cmp += 3;
      if (rsp_valid !== m_rsp_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, m_rsp_valid); end
      if (rsp_data !== m_rsp_data) begin n_bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rsp_data, m_rsp_data); end
      if (rd_count !== m_rd_count) begin n_bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, rd_count, m_rd_count); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_hold_rd();
    test_write_read();
    test_bit_write();
    test_back_to_back();
    test_mid_reset();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mem_cmd_ctrl.md
Name: seq_mem_cmd_ctrl

Overview:
Command front-end for a 16x8 scratchpad memory with whole-word writes, single-bit writes and registered reads. It accepts commands on a valid/ready interface and returns read data on a valid/ready response channel. After reset it clears every memory word before accepting any command. It is the stage upstream of the masked-write/registered-read memory stage and owns that stage's storage and its write and read sequencing.

Parameters:
DATA_W, 8, word width in bits
DEPTH, 16, number of words
ADDR_W, 4, address width; must equal $clog2(DEPTH)
IDX_W, 3, bit-index width; must equal $clog2(DATA_W)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  2'b00 CLR, 2'b01 WR_WORD, 2'b10 WR_BIT, 2'b11 RD
cmd_addr  in  ADDR_W  target word
cmd_bit_idx  in  IDX_W  bit position for WR_BIT
cmd_wdata  in  DATA_W  data for WR_WORD
cmd_bit_val  in  1  value for WR_BIT
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts rsp_data
rsp_data  out  DATA_W  read result
init_busy  out  1  high while the clear sweep runs
rd_count  out  8  number of accepted RD commands, wraps at 255

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM enters INIT; clear pointer = 0.
  - cmd_ready = 0, rsp_valid = 0, rsp_data = 0, init_busy = 1, rd_count = 0.
  - Memory contents are not reset directly; the INIT sweep clears them.
- FSM states: INIT, RUN.
- INIT:
  - Writes 0 to mem[ptr] each cycle, ptr increments by 1.
  - After the write to ptr = DEPTH-1, next state is RUN.
  - The sweep takes exactly DEPTH cycles after reset release.
  - init_busy = 1 and cmd_ready = 0 throughout.
- RUN:
  - init_busy = 0.
  - cmd_ready = !rsp_valid || rsp_ready (one-entry response buffer; a stalled response blocks new commands of every op).
  - cmd_ready is combinational from rsp_valid and rsp_ready only; it does not depend on cmd_valid.
- WR_WORD accepted at edge N: mem[cmd_addr] = cmd_wdata after edge N.
- WR_BIT accepted at edge N: mem[cmd_addr][cmd_bit_idx] = cmd_bit_val after edge N; all other bits unchanged.
- RD accepted at edge N:
  - rsp_data = mem[cmd_addr] as it was before edge N; rsp_valid = 1 after edge N (latency 1).
  - rd_count increments by 1, modulo 256.
  - A write accepted at N-1 is visible to a read accepted at N.
- Response handshake:
  - rsp_valid && rsp_ready with no new RD at the same edge: rsp_valid falls.
  - Handshake and a new RD accepted at the same edge: rsp_valid stays 1 and rsp_data takes the new value (back-to-back reads at full rate).
  - While rsp_valid && !rsp_ready: rsp_data holds stable.
- CLR: behaviour set by the optional feature below.
- cmd_valid is ignored while cmd_ready = 0; no command is queued.
- Asserting rst_n low mid-operation (including mid-INIT or with a pending response):
  - Pending response is dropped, rd_count = 0, and the INIT sweep restarts from address 0.
- Commands with out-of-range fields are impossible: DEPTH = 2^ADDR_W and DATA_W = 2^IDX_W.

Optional Feature:
Macro SEQ_MEM_CLR_CMD_EN.
- Defined: an accepted CLR command moves the FSM to INIT at the next edge and re-runs the full DEPTH-cycle sweep.
  - A pending response is preserved and its handshake still completes during INIT.
  - rd_count is unchanged.
- Undefined: CLR is accepted and acts as a NOP — no state change, no response, one-cycle acceptance.

Test Plan:
- Release reset, hold cmd_valid = 1 with RD addr 0 -> cmd_ready = 0 and init_busy = 1 for 16 cycles; RD accepted on cycle 17; rsp_data = 8'h00; rd_count = 1.
- WR_WORD addr 5 data 8'hA5, then RD addr 5 on the next cycle -> rsp_data = 8'hA5 one cycle after RD acceptance.
- WR_WORD addr 3 = 8'h0F, WR_BIT addr 3 idx 7 val 1, WR_BIT addr 3 idx 0 val 0, RD addr 3 -> rsp_data = 8'h8E.
- Issue RD addr 1, hold rsp_ready = 0 for 3 cycles with cmd_valid high -> cmd_ready = 0 and rsp_data stable for those cycles. Then back-to-back RDs with rsp_ready = 1 -> one response per cycle; rd_count increments by 1 per accepted RD.
- Assert rst_n low mid-INIT and also with rsp_valid = 1 -> outputs return to reset values immediately; the full 16-cycle sweep restarts; an earlier write to addr 5 reads back 8'h00.
- CLR after writing addr 9 = 8'h3C, then RD addr 9:
  - With SEQ_MEM_CLR_CMD_EN: init_busy = 1 for 16 cycles, then rsp_data = 8'h00.
  - Without the macro: no INIT sweep; rsp_data = 8'h3C.
